// File: rtl/div_sequencer.sv
// Operand FIFO plus issue/wait/hold sequencer that drives an external iterative divider
// and holds each result (or a watchdog timeout) until the consumer takes it.
module div_sequencer #(
  parameter int DEPTH = 4,
  parameter int TMO   = 31
) (
  input  logic        clk,
  input  logic        sclrn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [9:0]  in_a,
  input  logic [9:0]  in_b,
  output logic [9:0]  div_a,
  output logic [9:0]  div_b,
  output logic        div_start,
  output logic        div_sclr,
  input  logic        div_busy,
  input  logic        div_valid,
  input  logic        div_dvz,
  input  logic        div_ovf,
  input  logic [9:0]  div_q,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [9:0]  out_q,
  output logic        out_dvz,
  output logic        out_ovf,
  output logic        out_tmo,
  output logic [7:0]  done_cnt,
  output logic [7:0]  err_cnt
);

  localparam int DATA_W = 10;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [7:0]  TMO_M1   = 8'(TMO - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t state, state_nxt;

  logic [2*DATA_W-1:0] fifo_mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count;
  logic                full, empty, push, pop;
  logic [7:0]          wdog;
  logic                div_done, wdog_expire;

  assign full        = (count == FULL_CNT);
  assign empty       = (count == '0);
  assign in_ready    = sclrn & ~full;
  assign div_sclr    = ~sclrn;
  assign push        = in_valid & in_ready;
  assign div_done    = div_valid | div_dvz | div_ovf;
  assign wdog_expire = (wdog == TMO_M1);

  always_ff @(posedge clk) begin
    if (!sclrn) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !div_busy) begin
          state_nxt = ISSUE;
          pop       = 1'b1;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (div_done || wdog_expire) state_nxt = HOLD;
      end
      HOLD: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand FIFO: storage carries no reset, occupancy and pointers do
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {in_a, in_b};
  end

  always_ff @(posedge clk) begin
    if (!sclrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Divider interface, watchdog and result capture
  always_ff @(posedge clk) begin
    if (!sclrn) begin
      div_start <= 1'b0;
      div_a     <= '0;
      div_b     <= '0;
      wdog      <= '0;
      out_valid <= 1'b0;
      out_q     <= '0;
      out_dvz   <= 1'b0;
      out_ovf   <= 1'b0;
      out_tmo   <= 1'b0;
      done_cnt  <= '0;
      err_cnt   <= '0;
    end else begin
      div_start <= pop;
      if (pop) {div_a, div_b} <= fifo_mem[rd_ptr];
      case (state)
        ISSUE: wdog <= '0;
        WAIT: begin
          // a completion arriving on the expiry cycle still counts as a real result
          if (div_done) begin
            out_q     <= div_q;
            out_dvz   <= div_dvz;
            out_ovf   <= div_ovf;
            out_tmo   <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            wdog <= wdog + 8'd1;
            if (wdog_expire) begin
              out_q     <= '0;
              out_dvz   <= 1'b0;
              out_ovf   <= 1'b0;
              out_tmo   <= 1'b1;
              out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            done_cnt  <= done_cnt + 8'd1;
            if ((out_dvz | out_ovf | out_tmo) && (err_cnt != 8'hFF))
              err_cnt <= err_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 Parameter: DEPTH, default 4, operand FIFO entries (power of two, 2..16).
REQ-002 Parameter: TMO, default 31, maximum WAIT cycles before timeout (1..255).
REQ-003 CLK  in  1  single clock, all state updates on rising edge.
REQ-004 SCLRN  in  1  reset, synchronous and active-low.
REQ-005 IN_VALID  in  1  operand pair offered.
REQ-006 IN_READY  out  1  FIFO can accept; equals not-full.
REQ-007 IN_A  in  10  dividend.
REQ-008 IN_B  in  10  divisor.
REQ-009 DIV_A  out  10  dividend to divider AIN, registered.
REQ-010 DIV_B  out  10  divisor to divider BIN, registered.
REQ-011 DIV_START  out  1  one-cycle start pulse to divider START, registered.
REQ-012 DIV_SCLR  out  1  divider clear; equals not SCLRN.
REQ-013 DIV_BUSY, DIV_VALID, DIV_DVZ, DIV_OVF  in  1 each  divider status.
REQ-014 DIV_Q  in  10  divider QOUT.
REQ-015 OUT_VALID  out  1  result held for consumer.
REQ-016 OUT_READY  in  1  consumer accepts result.
REQ-017 OUT_Q  out  10  captured quotient.
REQ-018 OUT_DVZ, OUT_OVF, OUT_TMO  out  1 each  captured divide-by-zero, overflow, timeout flags.
REQ-019 DONE_CNT  out  8  results delivered, wraps 255->0.
REQ-020 ERR_CNT  out  8  results delivered with any flag set, saturates at 255.

Function
REQ-021 FIFO shall push {IN_A,IN_B} on IN_VALID and IN_READY; push when full is ignored; no same-cycle full pass-through.
REQ-022 FIFO shall pop only on the ISSUE transition; simultaneous push and pop when neither full nor empty keeps occupancy constant.
REQ-023 FSM states IDLE, ISSUE, WAIT, HOLD.
REQ-024 IDLE -> ISSUE when FIFO non-empty and DIV_BUSY=0; the transition loads DIV_A/DIV_B from FIFO head and pops.
REQ-025 ISSUE: DIV_START=1 for exactly this one cycle; next state WAIT; watchdog cleared to 0.
REQ-026 WAIT: completion is DIV_VALID or DIV_DVZ or DIV_OVF sampled high; on completion, capture DIV_Q, DIV_DVZ, DIV_OVF into OUT_*, OUT_TMO=0, OUT_VALID=1, next HOLD.
REQ-027 WAIT: watchdog increments each cycle without completion; on reaching TMO, OUT_Q=0, OUT_DVZ=0, OUT_OVF=0, OUT_TMO=1, OUT_VALID=1, next HOLD.
REQ-028 Completion and watchdog expiry in the same cycle: completion wins, OUT_TMO=0.
REQ-029 HOLD: OUT_* stable while OUT_READY=0; on OUT_READY=1, OUT_VALID=0 next cycle, DONE_CNT+1, ERR_CNT+1 if any flag set, next IDLE.
REQ-030 DIV_A/DIV_B shall hold their last value outside ISSUE.
REQ-031 Divider status inputs ignored in IDLE, ISSUE, HOLD.
REQ-032 Minimum latency: push at edge k -> DIV_START high in cycle after edge k+1; completion sampled at edge m -> OUT_VALID high after edge m.

Reset
REQ-033 SCLRN=0 at an edge: FSM IDLE, FIFO empty, watchdog 0, DONE_CNT=0, ERR_CNT=0, OUT_VALID=0, OUT_Q=0, all OUT flags 0, DIV_START=0, DIV_A=DIV_B=0.
REQ-034 IN_READY=0 and DIV_SCLR=1 while SCLRN=0.
REQ-035 Reset in any state, including mid-WAIT, discards in-flight operation and queued operands; no OUT_VALID results from them.

Verification
REQ-036 Push (100,7), OUT_READY=1, divider model -> one DIV_START pulse with DIV_A=100, DIV_B=7; OUT_Q=14, flags 0, DONE_CNT=1.
REQ-037 Push (5,0), divider asserts DVZ -> OUT_DVZ=1, OUT_Q=captured value, ERR_CNT=1.
REQ-038 DIV_BUSY forced 1, push 5 pairs -> IN_READY low after 4th, 5th ignored; release BUSY -> exactly 4 results in push order.
REQ-039 OUT_READY=0 for 20 cycles in HOLD -> OUT_* stable, no further DIV_START; raise OUT_READY -> next issue follows.
REQ-040 Divider never completes, TMO=31 -> OUT_TMO=1 exactly 31 WAIT cycles after ISSUE, OUT_Q=0.
REQ-041 SCLRN low for one cycle mid-WAIT with 2 queued -> all outputs at reset values, no results emitted, IN_READY=1 after release.
